// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC bus controller: state encoding, default bus phase
// length and the register index -> RTC address / BCD range tables.
package rtc_pkg;

    localparam int TPHASE_DEFAULT = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A1,
        ST_G1,
        ST_RD,
        ST_G2,
        ST_CALC,
        ST_A2,
        ST_G3,
        ST_WR,
        ST_G4,
        ST_DONE
    } state_t;

    function automatic logic [7:0] rtc_addr(input logic [2:0] dir);
        logic [7:0] a;
        case (dir)
            3'd1:    a = 8'h21;
            3'd2:    a = 8'h22;
            3'd3:    a = 8'h23;
            3'd4:    a = 8'h24;
            3'd5:    a = 8'h25;
            3'd6:    a = 8'h26;
            3'd7:    a = 8'h41;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] reg_min(input logic [2:0] dir);
        return ((dir == 3'd4) || (dir == 3'd5)) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] reg_max(input logic [2:0] dir);
        logic [7:0] m;
        case (dir)
            3'd3:    m = 8'h23;
            3'd4:    m = 8'h31;
            3'd5:    m = 8'h12;
            3'd6:    m = 8'h99;
            default: m = 8'h59;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl_bcd_step.sv
// One-step BCD increment/decrement with wrap inside [min_val, max_val]; a malformed
// or out-of-range input collapses to min_val.
module bcd_step (
    input  logic [7:0] value,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    input  logic       up,
    output logic [7:0] result
);

    logic [3:0] hi;
    logic [3:0] lo;
    logic       invalid;

    always_comb begin
        hi      = value[7:4];
        lo      = value[3:0];
        invalid = (hi > 4'd9) || (lo > 4'd9) || (value < min_val) || (value > max_val);
        result  = min_val;
        if (invalid) begin
            result = min_val;
        end else if (up) begin
            if (value == max_val)
                result = min_val;
            else if (lo == 4'd9)
                result = {hi + 4'd1, 4'd0};
            else
                result = {hi, lo + 4'd1};
        end else begin
            if (value == min_val)
                result = max_val;
            else if (lo == 4'd0)
                result = {hi - 4'd1, 4'd9};
            else
                result = {hi, lo - 4'd1};
        end
    end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Menu-side responder that runs RTC multiplexed-bus read and read-modify-write cycles.
// All bus outputs are registered from the current state, so they lag the state by one cycle.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int TPHASE = TPHASE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Acceso,
    input  logic [2:0] DIR,
    input  logic       Mod,
    input  logic       Numup,
    input  logic       Numdown,
    output logic       FRW,
    output logic [7:0] Dato,
    output logic [2:0] DatoDir,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam int CW = $clog2(TPHASE);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dir_q, dir_d;
    logic          mod_q, mod_d;
    logic          up_q, up_d;
    logic          down_q, down_d;
    logic [7:0]    rdval_q, rdval_d;
    logic [7:0]    newval_q, newval_d;
    logic [7:0]    step_res;
    logic [7:0]    min_val;
    logic [7:0]    max_val;
    logic          phase_end;
    logic          timed;
    logic          do_modify;

    logic          cs_n_q, cs_n_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          a_d_q, a_d_d;
    logic          ad_oe_q, ad_oe_d;
    logic [7:0]    ad_out_q, ad_out_d;
    logic          frw_q, frw_d;
    logic [7:0]    dato_q, dato_d;
    logic [2:0]    datodir_q, datodir_d;

    assign min_val   = reg_min(dir_q);
    assign max_val   = reg_max(dir_q);
    assign phase_end = (cnt_q == CW'(TPHASE - 1));
    // Either both or neither direction bit set degrades the request to a plain read.
    assign do_modify = mod_q & (up_q ^ down_q);

    bcd_step u_bcd_step (
        .value   (rdval_q),
        .min_val (min_val),
        .max_val (max_val),
        .up      (up_q),
        .result  (step_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mod_d    = mod_q;
        up_d     = up_q;
        down_d   = down_q;
        rdval_d  = rdval_q;
        newval_d = newval_q;
        timed    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Acceso) begin
                    dir_d    = DIR;
                    mod_d    = Mod;
                    up_d     = Numup;
                    down_d   = Numdown;
                    rdval_d  = 8'h00;
                    newval_d = 8'h00;
                    state_d  = (DIR == 3'd0) ? ST_DONE : ST_A1;
                end
            end
            ST_A1: begin
                timed = 1'b1;
                if (phase_end) state_d = ST_G1;
            end
            ST_G1: begin
                timed = 1'b1;
                if (phase_end) state_d = ST_RD;
            end
            ST_RD: begin
                timed = 1'b1;
                if (phase_end) begin
                    rdval_d = ad_in;
                    state_d = ST_G2;
                end
            end
            ST_G2: begin
                timed = 1'b1;
                if (phase_end) state_d = do_modify ? ST_CALC : ST_DONE;
            end
            ST_CALC: begin
                newval_d = step_res;
                state_d  = ST_A2;
            end
            ST_A2: begin
                timed = 1'b1;
                if (phase_end) state_d = ST_G3;
            end
            ST_G3: begin
                timed = 1'b1;
                if (phase_end) state_d = ST_WR;
            end
            ST_WR: begin
                timed = 1'b1;
                if (phase_end) state_d = ST_G4;
            end
            ST_G4: begin
                timed = 1'b1;
                if (phase_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timed)
            cnt_d = phase_end ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        a_d_d     = 1'b1;
        ad_oe_d   = 1'b0;
        ad_out_d  = 8'h00;
        frw_d     = 1'b0;
        dato_d    = dato_q;
        datodir_d = datodir_q;

        case (state_q)
            ST_A1, ST_A2: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = rtc_addr(dir_q);
            end
            ST_RD: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            ST_WR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = newval_q;
            end
            ST_DONE: begin
                frw_d     = 1'b1;
                dato_d    = do_modify ? newval_q : rdval_q;
                datodir_d = dir_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dir_q     <= 3'd0;
            mod_q     <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            rdval_q   <= 8'h00;
            newval_q  <= 8'h00;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            a_d_q     <= 1'b1;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= 8'h00;
            frw_q     <= 1'b0;
            dato_q    <= 8'h00;
            datodir_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            mod_q     <= mod_d;
            up_q      <= up_d;
            down_q    <= down_d;
            rdval_q   <= rdval_d;
            newval_q  <= newval_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            a_d_q     <= a_d_d;
            ad_oe_q   <= ad_oe_d;
            ad_out_q  <= ad_out_d;
            frw_q     <= frw_d;
            dato_q    <= dato_d;
            datodir_q <= datodir_d;
        end
    end

    assign CS_n    = cs_n_q;
    assign RD_n    = rd_n_q;
    assign WR_n    = wr_n_q;
    assign A_D     = a_d_q;
    assign ad_oe   = ad_oe_q;
    assign ad_out  = ad_out_q;
    assign FRW     = frw_q;
    assign Dato    = dato_q;
    assign DatoDir = datodir_q;

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Responder side of the menu/RTC access handshake. It accepts a register request (address index, optional increment/decrement) from the menu controller and runs the RTC multiplexed parallel bus cycles: address write, data read, and, when modifying, BCD adjust plus address/data write-back. It signals completion with a one-cycle `FRW` pulse and returns the register value. It sits between the menu FSMs and the top-level bus pads; tristating of the AD bus is done at top level.

## Interface
Parameters:
- `TPHASE`, 8: CLK cycles each bus phase (strobe or gap) lasts; ≥2.

Ports:
- `CLK`  in  1  clock
- `RST`  in  1  reset, asynchronous, active-high
- `Acceso`  in  1  request, level; sampled only in IDLE
- `DIR`  in  3  register index 0–7
- `Mod`  in  1  modify request (read-modify-write)
- `Numup`  in  1  increment when `Mod`
- `Numdown`  in  1  decrement when `Mod`
- `FRW`  out  1  one-cycle done pulse
- `Dato`  out  8  last value read, or written value after modify; valid from the `FRW` cycle
- `DatoDir`  out  3  index belonging to `Dato`
- `CS_n`, `RD_n`, `WR_n`  out  1 each  RTC strobes, active-low
- `A_D`  out  1  0 = address phase, 1 = data phase
- `ad_out`  out  8  bus drive value
- `ad_oe`  out  1  1 = top level drives AD
- `ad_in`  in  8  bus sample

## Operation
- Reset values: `CS_n`, `RD_n`, `WR_n`, `A_D` = 1; `ad_oe`, `ad_out`, `FRW`, `Dato`, `DatoDir` = 0; state IDLE. Strobes deassert asynchronously, including mid-transaction. No `FRW` follows a reset.
- States: IDLE, A1, G1, RD, G2, CALC, A2, G3, WR, G4, DONE.
- IDLE:
  - `Acceso`=1 latches `DIR`, `Mod`, `Numup`, `Numdown`.
  - `DIR`=0 goes to DONE; no bus activity.
  - Otherwise goes to A1.
  - Inputs are ignored in all other states.
- A1 / A2 (address write): `CS_n`=0, `WR_n`=0, `A_D`=0, `ad_oe`=1, `ad_out`=RTC address.
- G*: all strobes high, `ad_oe`=0.
- RD: `CS_n`=0, `RD_n`=0, `A_D`=1. `ad_in` is captured on the last RD cycle.
- G2 exit:
  - If `Mod` and exactly one of `Numup`/`Numdown` is set, go to CALC.
  - Else go to DONE (read only; `Mod` with 0 or 2 direction bits behaves the same).
- CALC: computes the new value in one cycle, then goes to A2.
- WR: `CS_n`=0, `WR_n`=0, `A_D`=1, `ad_oe`=1, `ad_out`=new value.
- DONE: `FRW`=1 for one cycle, update `Dato`/`DatoDir`, go to IDLE. If `Acceso` is still high, the next transaction is accepted on the following cycle.
- Address map (DIR→RTC address, min, max):
  - 1→0x21 sec 0x00–0x59
  - 2→0x22 min 0x00–0x59
  - 3→0x23 hour 0x00–0x23
  - 4→0x24 date 0x01–0x31
  - 5→0x25 month 0x01–0x12
  - 6→0x26 year 0x00–0x99
  - 7→0x41 timer 0x00–0x59
- BCD step:
  - Increment at max wraps to min. Otherwise low nibble 9 becomes 0 with carry into the high nibble.
  - Decrement at min wraps to max. Otherwise low nibble 0 becomes 9 with borrow from the high nibble.
  - Read value with a nibble >9, or outside min–max: either step writes min.

## Timing
- Acceptance edge is cycle 0.
- Each of A*, G*, RD, WR lasts exactly `TPHASE` cycles.
- Read-only: `FRW` at cycle 4·`TPHASE`+1.
- Modify: `FRW` at cycle 8·`TPHASE`+2.
- `DIR`=0: `FRW` at cycle 1.
- `ad_oe` changes only at phase boundaries. A_D and address/data are stable for the whole strobe phase. Gaps guarantee no overlap between drive and read.

## Structure
- Package `rtc_pkg`: state encoding, `TPHASE` default, DIR→address table, min/max tables.
- Sub-module `bcd_step` (combinational):
  - Inputs: value, min, max, up/down.
  - Output: wrapped BCD result.

## Test plan
- Reset mid-RD with `TPHASE`=4 → strobes high within the reset cycle; no `FRW`; IDLE after release.
- Read `DIR`=1, `ad_in`=0x45, `TPHASE`=4 → A1 drives 0x21 with `WR_n`/`A_D` low; `FRW` at cycle 17; `Dato`=0x45, `DatoDir`=1.
- Increment seconds, read 0x59 → WR phase drives 0x00; `FRW` at cycle 34; `Dato`=0x00.
- Decrement month, read 0x01 → writes 0x12. Increment hours, read 0x09 → writes 0x10. Increment date, read 0x3A → writes 0x01.
- `DIR`=0 with `Acceso` → `FRW` at cycle 1; `CS_n` never low.
- `Acceso` held high across `FRW`, back-to-back `DIR`=2 reads → second A1 begins two cycles after the first `FRW`. Changing `DIR` mid-transaction does not alter the driven address.
